vrc_selftest_ctrl: RTL and testbench

- Configuration and self-test controller for the satellite-FSM VRC fabric, whose inputs are I1, I2, I3, C1, C2, whose outputs are N1, N2, and whose configuration is an 86-bit Sel word.
- Stores up to NUM_CFG candidate Sel words and drives the active one onto the fabric.
- On request, it exhaustively tests the fabric against a golden truth table. On a mismatch it fails over to the next stored configuration.
- Sits between the mission logic and the VRC; passes mission inputs through when not testing.

---
 rtl/vrc_selftest_ctrl.sv | 171 +++++++++++++++++
 tb/tb_vrc_selftest_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vrc_selftest_ctrl.sv
// ---------------------------------------------------------------------------
// vrc_selftest_ctrl
//
// Configuration store and self-test sequencer for the satellite-FSM VRC
// fabric. Holds NUM_CFG candidate Sel words and drives the active one onto
// the fabric. On start_test it walks all 32 input vectors {I1,I2,I3,C1,C2},
// compares the fabric outputs {N1,N2} with the GOLDEN truth table, and on a
// mismatch fails over to the next stored configuration. Outside a test the
// mission inputs pass straight through to the fabric.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   cfg_wr_en    in   configuration store write strobe (ignored while busy)
//   cfg_wr_idx   in   store slot to write
//   cfg_wr_data  in   configuration word to write
//   start_test   in   single-cycle pulse starting a self-test
//   mission_in   in   {I1,I2,I3,C1,C2} from the mission logic
//   vrc_out      in   {N1,N2} from the fabric
//   vrc_in       out  {I1,I2,I3,C1,C2} to the fabric
//   sel          out  active configuration word, store[cfg_idx]
//   cfg_idx      out  index of the active configuration
//   busy         out  self-test in progress
//   pass         out  last test passed (sticky until next accepted start)
//   all_failed   out  every configuration failed (sticky until next start)
// ---------------------------------------------------------------------------
module vrc_selftest_ctrl #(
    parameter int          SEL_W   = 86,
    parameter int          NUM_CFG = 4,
    parameter int          SETTLE  = 2,
    parameter logic [63:0] GOLDEN  = 64'h0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_wr_en,
    input  logic [$clog2(NUM_CFG)-1:0] cfg_wr_idx,
    input  logic [SEL_W-1:0]           cfg_wr_data,
    input  logic                       start_test,
    input  logic [4:0]                 mission_in,
    input  logic [1:0]                 vrc_out,
    output logic [4:0]                 vrc_in,
    output logic [SEL_W-1:0]           sel,
    output logic [$clog2(NUM_CFG)-1:0] cfg_idx,
    output logic                       busy,
    output logic                       pass,
    output logic                       all_failed
);

    localparam int IDX_W = $clog2(NUM_CFG);
    localparam int CNT_W = $clog2(SETTLE + 1);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CFG - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_APPLY    = 3'd1;
    localparam logic [2:0] S_WAIT     = 3'd2;
    localparam logic [2:0] S_CHECK    = 3'd3;
    localparam logic [2:0] S_FAILOVER = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [SEL_W-1:0] r_store [NUM_CFG];
    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_cfg_idx;
    logic [4:0]       r_vector;
    logic [4:0]       r_test_vec;
    logic [CNT_W-1:0] r_settle;
    logic             r_busy;
    logic             r_pass;
    logic             r_all_failed;

    logic [1:0]       w_golden;
    logic             w_store_wr;

    assign w_golden   = GOLDEN[{r_vector, 1'b0} +: 2];
    assign w_store_wr = cfg_wr_en && !r_busy;

    // NOTE: the store is a register array with a full reset, not a RAM, so
    // that sel is a defined all-zero word straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                r_store[i] <= '0;
            end
        end else if (w_store_wr) begin
            r_store[cfg_wr_idx] <= cfg_wr_data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every branch
    // below reads the values from before this edge, whatever the order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cfg_idx    <= '0;
            r_vector     <= '0;
            r_test_vec   <= '0;
            r_settle     <= '0;
            r_busy       <= 1'b0;
            r_pass       <= 1'b0;
            r_all_failed <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // busy is still high for the first IDLE cycle after DONE;
                    // a start arriving then is ignored like any other start
                    // while busy.
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (start_test) begin
                        r_state      <= S_APPLY;
                        r_busy       <= 1'b1;
                        r_pass       <= 1'b0;
                        r_all_failed <= 1'b0;
                        r_vector     <= '0;
                    end
                end
                S_APPLY: begin
                    r_test_vec <= r_vector;
                    r_settle   <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    r_settle <= r_settle + 1'b1;
                    if (r_settle == SETTLE_LAST) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (vrc_out == w_golden) begin
                        if (r_vector == 5'd31) begin
                            r_pass  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_vector <= r_vector + 5'd1;
                            r_state  <= S_APPLY;
                        end
                    end else begin
                        r_state <= S_FAILOVER;
                    end
                end
                S_FAILOVER: begin
                    // sel follows cfg_idx combinationally, so the new word is
                    // on the fabric during APPLY and settles before CHECK.
                    if (r_cfg_idx == LAST_IDX) begin
                        r_all_failed <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_cfg_idx <= r_cfg_idx + 1'b1;
                        r_vector  <= '0;
                        r_state   <= S_APPLY;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign vrc_in     = r_busy ? r_test_vec : mission_in;
    assign sel        = r_store[r_cfg_idx];
    assign cfg_idx    = r_cfg_idx;
    assign busy       = r_busy;
    assign pass       = r_pass;
    assign all_failed = r_all_failed;

endmodule

// File: tb/tb_vrc_selftest_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vrc_selftest_ctrl
//
// Self-checking bench for vrc_selftest_ctrl. A behavioural fabric model
// answers from the golden table, except where a configuration word asks it
// to corrupt one vector: bit 5 enables the fault, bits [4:0] give the vector
// and bits [7:6] (non-zero) are XORed into {N1,N2}. Expected outcomes (run
// length, final slot, pass/all_failed) are computed from the scan rules.
// ---------------------------------------------------------------------------
module tb_vrc_selftest_ctrl;

    localparam int          S = 2;
    localparam logic [63:0] G = 64'hA5A5_0F0F_3C3C_9696;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_wr_en;
    logic [1:0]  cfg_wr_idx;
    logic [85:0] cfg_wr_data;
    logic        start_test;
    logic [4:0]  mission_in;
    logic [1:0]  vrc_out;
    logic [4:0]  vrc_in;
    logic [85:0] sel;
    logic [1:0]  cfg_idx;
    logic        busy;
    logic        pass;
    logic        all_failed;

    int checks = 0;
    int errors = 0;

    logic [85:0] m_store [4];
    int          m_idx;

    vrc_selftest_ctrl #(
        .SEL_W  (86),
        .NUM_CFG(4),
        .SETTLE (S),
        .GOLDEN (G)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_wr_en  (cfg_wr_en),
        .cfg_wr_idx (cfg_wr_idx),
        .cfg_wr_data(cfg_wr_data),
        .start_test (start_test),
        .mission_in (mission_in),
        .vrc_out    (vrc_out),
        .vrc_in     (vrc_in),
        .sel        (sel),
        .cfg_idx    (cfg_idx),
        .busy       (busy),
        .pass       (pass),
        .all_failed (all_failed)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] fabric(input logic [85:0] w, input logic [4:0] v);
        logic [63:0] gold;
        logic [1:0]  o;
        gold = G;
        o = gold[2*v +: 2];
        if (w[5] && (w[4:0] == v)) o = o ^ w[7:6];
        return o;
    endfunction

    assign vrc_out = fabric(sel, vrc_in);

    function automatic int first_fail(input logic [85:0] w);
        return w[5] ? int'(w[4:0]) : 32;
    endfunction

    function automatic logic [85:0] make_word(input bit en, input logic [4:0] fv);
        logic [85:0] w;
        w = {$urandom, $urandom, $urandom};
        w[4:0] = fv;
        w[5]   = en;
        w[7:6] = 2'($urandom_range(1, 3));
        return w;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mission_in = 5'($urandom);
        #1;
        check("rst_sel", sel, 0);
        check("rst_busy", busy, 0);
        check("rst_pass", pass, 0);
        check("rst_allf", all_failed, 0);
        check("rst_idx", cfg_idx, 0);
        check("rst_vrc_in", vrc_in, mission_in);
        for (int i = 0; i < 4; i++) m_store[i] = '0;
        m_idx = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_write(input logic [1:0] idx, input logic [85:0] data);
        cfg_wr_en   = 1'b1;
        cfg_wr_idx  = idx;
        cfg_wr_data = data;
        @(negedge clk);
        cfg_wr_en = 1'b0;
        m_store[idx] = data;
        check("wr_sel", sel, m_store[m_idx]);
    endtask

    // Starts a test (optionally with a store write in the same cycle), pokes
    // a dropped write and an ignored start while busy, then checks the run
    // length, flag timing and final state against the scan model.
    task automatic run_test(input bit wr_start, input logic [1:0] ws_idx,
                            input logic [85:0] ws_data, input logic [1:0] bw_idx,
                            input logic [85:0] bw_data);
        int idx, total, f, cnt, flag_at;
        bit exp_pass, exp_all;
        start_test = 1'b1;
        if (wr_start) begin
            cfg_wr_en   = 1'b1;
            cfg_wr_idx  = ws_idx;
            cfg_wr_data = ws_data;
            m_store[ws_idx] = ws_data;
        end
        idx = m_idx; total = 0; exp_pass = 0; exp_all = 0;
        for (int k = 0; k < 8; k++) begin
            f = first_fail(m_store[idx]);
            if (f == 32) begin
                total += 32 * (S + 2) + 2;
                exp_pass = 1;
                break;
            end
            total += (f + 1) * (S + 2) + 1;
            if (idx == 3) begin
                total += 2;
                exp_all = 1;
                break;
            end
            idx++;
        end
        @(negedge clk);
        start_test = 1'b0;
        cfg_wr_en  = 1'b0;
        cnt = 0; flag_at = -1;
        while (busy === 1'b1 && cnt < 4000) begin
            cnt++;
            if ((pass || all_failed) && flag_at < 0) flag_at = cnt;
            start_test  = (cnt == 3);
            cfg_wr_en   = (cnt == 5);
            cfg_wr_idx  = bw_idx;
            cfg_wr_data = bw_data;
            @(negedge clk);
        end
        start_test = 1'b0;
        cfg_wr_en  = 1'b0;
        check("busy_len", cnt, total);
        check("flag_time", flag_at, total - 1);
        check("pass", pass, exp_pass);
        check("all_failed", all_failed, exp_all);
        check("cfg_idx", cfg_idx, idx);
        check("sel", sel, m_store[idx]);
        m_idx = idx;
    endtask

    initial begin
        logic [85:0] w;
        cfg_wr_en = 1'b0; cfg_wr_idx = '0; cfg_wr_data = '0;
        start_test = 1'b0; mission_in = '0;
        @(negedge clk);
        do_reset();

        // Idle pass-through
        mission_in = 5'b10101;
        #1 check("idle_passthru", vrc_in, 5'b10101);

        // Golden pass on an all-zero store, with a dropped write to slot 0
        run_test(0, 2'd0, '0, 2'd0, 86'h1);
        check("drop_wr", sel, 86'h0);
        do_write(2'd0, 86'h1);
        check("wr_after", sel, 86'h1);

        // Single failover: slot 0 flips N2 at vector 7, slot 1 correct
        w = make_word(1, 5'd7);
        w[7:6] = 2'b01;
        do_write(2'd0, w);
        do_write(2'd1, make_word(0, 5'd0));
        run_test(0, 2'd0, '0, 2'd2, make_word(1, 5'd0));

        // Reset around vector 15 while testing slot 1
        start_test = 1'b1;
        @(negedge clk);
        start_test = 1'b0;
        repeat (15 * (S + 2)) @(negedge clk);
        check("busy_mid", busy, 1);
        do_reset();

        // All slots fail at vector 0, then a retest covers only slot 3
        for (int i = 0; i < 4; i++) do_write(2'(i), make_word(1, 5'd0));
        run_test(0, 2'd0, '0, 2'd1, '0);
        run_test(0, 2'd0, '0, 2'd1, '0);

        // Randomised trials
        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 3) == 0) do_reset();
            for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                do_write(2'($urandom), make_word($urandom_range(0, 2) != 0, 5'($urandom)));
            mission_in = 5'($urandom);
            #1 check("rand_passthru", vrc_in, mission_in);
            run_test($urandom_range(0, 1) == 1, 2'($urandom),
                     make_word($urandom_range(0, 2) != 0, 5'($urandom)),
                     2'($urandom), make_word($urandom_range(0, 1) == 1, 5'($urandom)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
